oled_frame_arbiter: RTL

//  Shares the single 96x64 OLED pixel stream between N student task pixel generators.

---
 rtl/oled_pkg.sv | 21 ++
 rtl/oled_rr_pick.sv | 32 +++
 rtl/oled_frame_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/oled_pkg.sv
// Shared constants and types for the OLED frame arbiter.
// Display geometry, pixel format defaults and the arbiter state encoding.
package oled_pkg;

    localparam int OLED_W    = 96;
    localparam int OLED_H    = 64;
    localparam int PIX_W_DEF = 16;

    localparam logic [15:0] IDLE_COLOR = 16'h0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    // Width of an index into n sources, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/oled_rr_pick.sv
// Round-robin source picker: first requester after last_owner_i, wrapping.
// Purely combinational; the owner itself is the last candidate examined.
module oled_rr_pick
    import oled_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int IDX_W = idx_width(N_SRC)
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [IDX_W-1:0] last_owner_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    int cand;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        found_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        // Walk the ring backwards so the nearest requester after last_owner wins the final write.
        for (int k = N_SRC; k >= 1; k--) begin
            cand = (int'(last_owner_i) + k) % N_SRC;
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/oled_frame_arbiter.sv
// Frame-boundary arbiter sharing one OLED pixel stream between N_SRC generators.
// Ownership only moves on frame_begin, round-robin, with a minimum hold and a lock.
module oled_frame_arbiter
    import oled_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int HOLD_FRAMES = 8,
    parameter int PIX_W       = PIX_W_DEF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   frame_begin,
    input  logic [N_SRC-1:0]       req,
    input  logic                   lock,
    input  logic [N_SRC*PIX_W-1:0] src_data,
    output logic [PIX_W-1:0]       pixel_data,
    output logic [N_SRC-1:0]       grant,
    output logic                   grant_valid,
    output logic                   switch_pulse,
    output logic [7:0]             frame_count
);

    localparam int IDX_W = idx_width(N_SRC);
    localparam int HC_W  = $clog2(HOLD_FRAMES) + 1;
    localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(HOLD_FRAMES - 1);

    arb_state_e        state_q, state_d;
    logic [N_SRC-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  last_owner_q, last_owner_d;
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic              switch_pulse_q, switch_pulse_d;
    logic [7:0]        frame_count_q, frame_count_d;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [N_SRC-1:0]  pick_onehot;
    logic [HC_W-1:0]   hold_inc;
    logic              owner_req;
    logic              contender;

    oled_rr_pick #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i        (req),
        .last_owner_i (last_owner_q),
        .found_o      (pick_found),
        .idx_o        (pick_idx)
    );

    always_comb begin
        pick_onehot           = '0;
        pick_onehot[pick_idx] = 1'b1;
    end

    assign hold_inc  = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;
    assign owner_req = |(req & grant_q);
    assign contender = |(req & ~grant_q);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_owner_d  = last_owner_q;
        hold_cnt_d    = hold_cnt_q;
        frame_count_d = frame_count_q;

        if (frame_begin) begin
            frame_count_d = frame_count_q + 8'd1;
            unique case (state_q)
                ST_IDLE: begin
                    // lock is deliberately ignored here: an idle display is always claimable.
                    if (|req) begin
                        grant_d      = pick_onehot;
                        last_owner_d = pick_idx;
                        hold_cnt_d   = '0;
                        state_d      = ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (lock) begin
                        hold_cnt_d = hold_inc;
                    end else if (!owner_req) begin
                        if (pick_found) begin
                            grant_d      = pick_onehot;
                            last_owner_d = pick_idx;
                            hold_cnt_d   = '0;
                        end else begin
                            grant_d = '0;
                            state_d = ST_IDLE;
                        end
                    end else if (contender && hold_cnt_q == HOLD_MAX) begin
                        // Owner sits last in its own rr ring, so a contender is always chosen first.
                        grant_d      = pick_onehot;
                        last_owner_d = pick_idx;
                        hold_cnt_d   = '0;
                    end else begin
                        hold_cnt_d = hold_inc;
                    end
                end
                default: begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end

        switch_pulse_d = (grant_d != grant_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            grant_q        <= '0;
            last_owner_q   <= IDX_W'(N_SRC - 1);
            hold_cnt_q     <= '0;
            switch_pulse_q <= 1'b0;
            frame_count_q  <= 8'd0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_owner_q   <= last_owner_d;
            hold_cnt_q     <= hold_cnt_d;
            switch_pulse_q <= switch_pulse_d;
            frame_count_q  <= frame_count_d;
        end
    end

    // Zero-latency pixel path keyed on the registered grant, so reset blanks it at once.
    always_comb begin
        pixel_data = PIX_W'(IDLE_COLOR);
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_q[i]) begin
                pixel_data = src_data[i*PIX_W +: PIX_W];
            end
        end
    end

    assign grant        = grant_q;
    assign grant_valid  = (state_q == ST_OWN);
    assign switch_pulse = switch_pulse_q;
    assign frame_count  = frame_count_q;

endmodule
